// File: rtl/hostmem_chan_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hostmem_chan_arbiter_pkg
// Description : Shared types and constants for the hostmem channel arbiter.
//               Owner encoding, the read-tracking entry and the arbiter
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hostmem_chan_arbiter_pkg;

  localparam int HOSTMEM_ARB_RD_TRACK_DEPTH = 64;
  localparam int HOSTMEM_ARB_BURST_W        = 5;

  typedef logic [HOSTMEM_ARB_BURST_W-1:0] hostmem_arb_bc_t;

  typedef enum logic {
    OWNER_DMA = 1'b0,
    OWNER_USM = 1'b1
  } hostmem_arb_owner_e;

  // One entry per outstanding read burst: who issued it and how many beats
  // are still expected back.
  typedef struct packed {
    hostmem_arb_owner_e owner;
    hostmem_arb_bc_t    burstcount;
  } rd_track_t;

  typedef enum logic [0:0] {
    ST_ARB     = 1'b0,
    ST_WR_LOCK = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/hostmem_arb_rd_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hostmem_arb_rd_tracker
// Description : Tracks outstanding host read bursts in issue order and steers
//               returning read beats to the requester that issued them.
//               Read data is registered: one cycle from host to requester.
// Ports       : clk_i, rst_ni              - clock, async active-low reset
//               push_i, push_entry_i       - record an accepted read burst
//               full_o                     - registered tracking-FIFO full
//               host_readdata*_i           - returning host read beats
//               {dma,usm}_readdata*_o      - steered, registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module hostmem_arb_rd_tracker
  import hostmem_chan_arbiter_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = HOSTMEM_ARB_RD_TRACK_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  rd_track_t         push_entry_i,
  output logic              full_o,
  input  logic              host_readdatavalid_i,
  input  logic [DATA_W-1:0] host_readdata_i,
  output logic [DATA_W-1:0] dma_readdata_o,
  output logic              dma_readdatavalid_o,
  output logic [DATA_W-1:0] usm_readdata_o,
  output logic              usm_readdatavalid_o
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  rd_track_t         mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q;
  hostmem_arb_bc_t   resp_cnt_q, resp_cnt_d, resp_cnt_inc;
  logic              err_orphan_rsp_q;
  logic [DATA_W-1:0] dma_rdata_q, usm_rdata_q;
  logic              dma_rvalid_q, usm_rvalid_q;

  rd_track_t head;
  logic      empty, rsp_ok, pop;

  assign head         = mem_q[rd_ptr_q];
  assign empty        = (count_q == '0);
  assign rsp_ok       = host_readdatavalid_i && !empty;
  assign resp_cnt_inc = resp_cnt_q + hostmem_arb_bc_t'(1);
  // The last beat of the head burst retires the entry.
  assign pop          = rsp_ok && (resp_cnt_inc == head.burstcount);

  always_comb begin
    count_d = count_q;
    if (push_i && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!push_i && pop) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_comb begin
    resp_cnt_d = resp_cnt_q;
    if (pop) begin
      resp_cnt_d = '0;
    end else if (rsp_ok) begin
      resp_cnt_d = resp_cnt_inc;
    end
  end

  // Tracking storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      full_q           <= 1'b0;
      resp_cnt_q       <= '0;
      err_orphan_rsp_q <= 1'b0;
      dma_rdata_q      <= '0;
      usm_rdata_q      <= '0;
      dma_rvalid_q     <= 1'b0;
      usm_rvalid_q     <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      // Full is taken from the next count so a filling push blocks reads
      // from the very next cycle.
      full_q     <= (count_d == C_DEPTH);
      resp_cnt_q <= resp_cnt_d;
      if (host_readdatavalid_i && empty) err_orphan_rsp_q <= 1'b1;
      dma_rvalid_q <= rsp_ok && (head.owner == OWNER_DMA);
      usm_rvalid_q <= rsp_ok && (head.owner == OWNER_USM);
      // The non-owner keeps its last data.
      if (rsp_ok && (head.owner == OWNER_DMA)) dma_rdata_q <= host_readdata_i;
      if (rsp_ok && (head.owner == OWNER_USM)) usm_rdata_q <= host_readdata_i;
    end
  end

  assign full_o              = full_q;
  assign dma_readdata_o      = dma_rdata_q;
  assign dma_readdatavalid_o = dma_rvalid_q;
  assign usm_readdata_o      = usm_rdata_q;
  assign usm_readdatavalid_o = usm_rvalid_q;

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !err_orphan_rsp_q);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_q));

endmodule
`default_nettype wire

// File: rtl/hostmem_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hostmem_chan_arbiter
// Description : Shares one host-memory AVMM channel between the DMA and USM
//               requesters. Round-robin at burst boundaries, grant locked for
//               multi-beat write bursts, read responses steered by owner.
// Ports       : clk_i, reset_n_i                 - clock, async active-low rst
//               {dma,usm}_read/write/address/burstcount/writedata/byteenable_i
//               {dma,usm}_waitrequest_o           - per-requester backpressure
//               {dma,usm}_readdata/readdatavalid_o - steered read data
//               host_*_o / host_*_i               - PIM host-channel AVMM
// Revision    : 1.0 - initial release
// ============================================================================
module hostmem_chan_arbiter
  import hostmem_chan_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 48,
  parameter int DATA_W         = 512,
  parameter int BURST_W        = 5,
  parameter int RD_TRACK_DEPTH = HOSTMEM_ARB_RD_TRACK_DEPTH
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                dma_read_i,
  input  logic                dma_write_i,
  input  logic [ADDR_W-1:0]   dma_address_i,
  input  logic [BURST_W-1:0]  dma_burstcount_i,
  input  logic [DATA_W-1:0]   dma_writedata_i,
  input  logic [DATA_W/8-1:0] dma_byteenable_i,
  output logic                dma_waitrequest_o,
  output logic [DATA_W-1:0]   dma_readdata_o,
  output logic                dma_readdatavalid_o,
  input  logic                usm_read_i,
  input  logic                usm_write_i,
  input  logic [ADDR_W-1:0]   usm_address_i,
  input  logic [BURST_W-1:0]  usm_burstcount_i,
  input  logic [DATA_W-1:0]   usm_writedata_i,
  input  logic [DATA_W/8-1:0] usm_byteenable_i,
  output logic                usm_waitrequest_o,
  output logic [DATA_W-1:0]   usm_readdata_o,
  output logic                usm_readdatavalid_o,
  output logic                host_read_o,
  output logic                host_write_o,
  output logic [ADDR_W-1:0]   host_address_o,
  output logic [BURST_W-1:0]  host_burstcount_o,
  output logic [DATA_W-1:0]   host_writedata_o,
  output logic [DATA_W/8-1:0] host_byteenable_o,
  input  logic                host_waitrequest_i,
  input  logic [DATA_W-1:0]   host_readdata_i,
  input  logic                host_readdatavalid_i
);

  arb_state_e         state_q, state_d;
  hostmem_arb_owner_e lock_owner_q, lock_owner_d;
  hostmem_arb_owner_e last_q, last_d;
  logic [BURST_W-1:0] beats_left_q, beats_left_d;

  hostmem_arb_owner_e win;
  logic               gnt, dma_elig, usm_elig, sel_read, sel_write;
  logic               rd_full, accept, push;
  rd_track_t          push_entry;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_ARB;
      lock_owner_q <= OWNER_DMA;
      last_q       <= OWNER_USM;  // DMA wins the first contended grant
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      last_q       <= last_d;
      beats_left_q <= beats_left_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    last_d       = last_q;
    beats_left_d = beats_left_q;
    case (state_q)
      ST_ARB: begin
        if (accept) begin
          last_d = win;
          if (host_write_o && (host_burstcount_o > BURST_W'(1))) begin
            state_d      = ST_WR_LOCK;
            lock_owner_d = win;
            beats_left_d = host_burstcount_o - BURST_W'(1);
          end
        end
      end
      ST_WR_LOCK: begin
        if (accept) begin
          beats_left_d = beats_left_q - BURST_W'(1);
          if (beats_left_q == BURST_W'(1)) state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    // A read only competes while there is room to track its response.
    dma_elig = dma_write_i || (dma_read_i && !rd_full);
    usm_elig = usm_write_i || (usm_read_i && !rd_full);
    win      = OWNER_DMA;
    gnt      = 1'b0;
    if (state_q == ST_WR_LOCK) begin
      win = lock_owner_q;
      gnt = 1'b1;
    end else begin
      gnt = dma_elig || usm_elig;
      if (dma_elig && usm_elig) begin
        win = (last_q == OWNER_DMA) ? OWNER_USM : OWNER_DMA;
      end else if (usm_elig) begin
        win = OWNER_USM;
      end
    end

    if (win == OWNER_USM) begin
      sel_read          = usm_read_i;
      sel_write         = usm_write_i;
      host_address_o    = usm_address_i;
      host_burstcount_o = usm_burstcount_i;
      host_writedata_o  = usm_writedata_i;
      host_byteenable_o = usm_byteenable_i;
    end else begin
      sel_read          = dma_read_i;
      sel_write         = dma_write_i;
      host_address_o    = dma_address_i;
      host_burstcount_o = dma_burstcount_i;
      host_writedata_o  = dma_writedata_i;
      host_byteenable_o = dma_byteenable_i;
    end

    // During a locked burst only the owner's write beats go out.
    host_read_o       = gnt && (state_q == ST_ARB) && sel_read && !rd_full;
    host_write_o      = gnt && sel_write;
    dma_waitrequest_o = !(gnt && (win == OWNER_DMA)) || host_waitrequest_i;
    usm_waitrequest_o = !(gnt && (win == OWNER_USM)) || host_waitrequest_i;
  end

  assign accept                = (host_read_o || host_write_o) && !host_waitrequest_i;
  assign push                  = host_read_o && !host_waitrequest_i;
  assign push_entry.owner      = win;
  assign push_entry.burstcount = hostmem_arb_bc_t'(host_burstcount_o);

  hostmem_arb_rd_tracker #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_TRACK_DEPTH)
  ) u_rd_tracker (
    .clk_i                (clk_i),
    .rst_ni               (reset_n_i),
    .push_i               (push),
    .push_entry_i         (push_entry),
    .full_o               (rd_full),
    .host_readdatavalid_i (host_readdatavalid_i),
    .host_readdata_i      (host_readdata_i),
    .dma_readdata_o       (dma_readdata_o),
    .dma_readdatavalid_o  (dma_readdatavalid_o),
    .usm_readdata_o       (usm_readdata_o),
    .usm_readdatavalid_o  (usm_readdatavalid_o)
  );

  a_bc_nonzero: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((state_q == ST_ARB) && (host_read_o || host_write_o)) |-> (host_burstcount_o != '0));

endmodule
`default_nettype wire
